// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and helpers for alu_seq
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_SHR1 = 4'd5;
  localparam logic [3:0] OP_SHL1 = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHLN = 4'd8;
  localparam logic [3:0] OP_SHRN = 4'd9;
  localparam logic [3:0] OP_SARN = 4'd10;
  localparam logic [3:0] OP_ADDC = 4'd11;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  function automatic logic is_shiftn(input logic [3:0] op);
    return op == OP_SHLN || op == OP_SHRN || op == OP_SARN;
  endfunction
  function automatic logic is_arith(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_ADDC;
  endfunction
endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle ALU ops producing result, carry, overflow and illegal-op flag
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             err
);
  localparam int M = WIDTH - 1;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, op == OP_ADDC && cin};
    dif    = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        result = sum[M:0];
        carry  = sum[WIDTH];
        ovf    = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        result = dif[M:0];
        carry  = dif[WIDTH];
        ovf    = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHR1: begin
        result = a >> 1;
        carry  = a[0];
      end
      OP_SHL1: begin
        result = a << 1;
        carry  = a[M];
      end
      OP_SHLN, OP_SHRN, OP_SARN: result = a;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, flags, stored carry and iterative shifts
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err
);
  localparam int SHW = $clog2(WIDTH);
  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   n;
  logic [WIDTH-1:0] work;
  logic [3:0]       wop;
  logic             carry_reg;
  logic             accept;
  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_ovf;
  logic             c_err;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  assign n        = in_b[SHW-1:0];
  assign in_ready = state == ST_IDLE && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a(in_a),
    .b(in_b),
    .op(in_op),
    .cin(carry_reg),
    .result(c_res),
    .carry(c_carry),
    .ovf(c_ovf),
    .err(c_err)
  );
  always_comb begin
    sh_next = wop == OP_SHLN ? work << 1 :
              wop == OP_SHRN ? work >> 1 : {work[WIDTH-1], work[WIDTH-1:1]};
    sh_out  = wop == OP_SHLN ? work[WIDTH-1] : work[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      work       <= '0;
      wop        <= '0;
      carry_reg  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept && is_shiftn(in_op) && n != '0) begin
          work  <= in_a;
          cnt   <= n;
          wop   <= in_op;
          state <= ST_SHIFT;
        end else if (accept) begin
          out_valid  <= 1'b1;
          out_result <= c_res;
          out_zero   <= !c_err && c_res == '0;
          out_neg    <= c_res[WIDTH-1];
          out_carry  <= c_carry;
          out_ovf    <= c_ovf;
          out_err    <= c_err;
          if (is_arith(in_op)) carry_reg <= c_carry;
        end
      end else begin
        work <= sh_next;
        cnt  <= cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          state      <= ST_IDLE;
          out_valid  <= 1'b1;
          out_result <= sh_next;
          out_zero   <= sh_next == '0;
          out_neg    <= sh_next[WIDTH-1];
          out_carry  <= sh_out;
          out_ovf    <= 1'b0;
          out_err    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with scoreboard queue and decoupled output monitor
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_neg;
  logic       out_carry;
  logic       out_ovf;
  logic       out_err;
  logic [12:0] expq[$];
  logic [12:0] e;
  int checks = 0;
  int passes = 0;
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_zero(out_zero),
    .out_neg(out_neg),
    .out_carry(out_carry),
    .out_ovf(out_ovf),
    .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) chk("unexpected_result", 32'(out_result), 32'hDEAD);
      else begin
        e = expq.pop_front();
        chk("result{res,z,n,c,v,e}", 32'({out_result, out_zero, out_neg, out_carry, out_ovf, out_err}), 32'(e));
      end
    end
  end
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [12:0] exp, input bit push = 1'b1);
    int t;
    if (push) expq.push_back(exp);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'({out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_err}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(4'd0, 8'hFF, 8'h01, {8'h00, 5'b10100});
    issue(4'd11, 8'h00, 8'h00, {8'h01, 5'b00000});
    issue(4'd1, 8'h80, 8'h01, {8'h7F, 5'b00010});
    issue(4'd1, 8'h01, 8'h02, {8'hFF, 5'b01100});
    issue(4'd10, 8'h90, 8'h03, {8'hF2, 5'b01000});
    repeat (3) begin
      @(negedge clk);
      chk("sarn_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("sarn_valid_4th", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    issue(4'd8, 8'h81, 8'h00, {8'h81, 5'b01000});
    @(negedge clk);
    chk("shln0_latency1", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'd7, 8'hF0, 8'hFF, {8'h0F, 5'b00000});
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", 32'({out_valid, in_ready, out_result}), 32'({1'b1, 1'b0, 8'h0F}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(4'd2, 8'hF0, 8'h3C, {8'h30, 5'b00000});
    @(negedge clk);
    chk("b2b_no_bubble", 32'({out_valid, out_result}), 32'({1'b1, 8'h30}));
    @(posedge clk);
    #1;
    issue(4'd3, 8'h0F, 8'hF0, {8'hFF, 5'b01000});
    issue(4'd4, 8'h55, 8'h00, {8'hAA, 5'b01000});
    issue(4'd5, 8'h03, 8'h00, {8'h01, 5'b00100});
    issue(4'd6, 8'h81, 8'h00, {8'h02, 5'b00100});
    issue(4'd13, 8'hFF, 8'hFF, {8'h00, 5'b00001});
    issue(4'd11, 8'h00, 8'h00, {8'h01, 5'b00000});
    issue(4'd8, 8'h81, 8'h01, {8'h02, 5'b00100});
    issue(4'd9, 8'h81, 8'h07, {8'h01, 5'b00000});
    issue(4'd10, 8'h81, 8'h0F, {8'hFF, 5'b01000});
    issue(4'd0, 8'h7F, 8'h01, {8'h80, 5'b01010});
    issue(4'd0, 8'hFF, 8'hFF, {8'hFE, 5'b01100});
    issue(4'd9, 8'hFF, 8'h06, 13'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", 32'({out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(4'd11, 8'h01, 8'h01, {8'h02, 5'b00000});
    t = 0;
    while (expq.size() != 0 && t < 50) begin
      t++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("drain", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
